// File: rtl/sand_update_scheduler_if.sv
// Cell-memory, control and brush-write signals shared by the sand scheduler and its environment.
interface sand_update_scheduler_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  start_i;
  logic                  busy_o;
  logic                  done_o;
  logic [ADDR_WIDTH-1:0] rd_address_1_o;
  logic [ADDR_WIDTH-1:0] rd_address_2_o;
  logic [DATA_WIDTH-1:0] rd_data_1_i;
  logic [DATA_WIDTH-1:0] rd_data_2_i;
  logic                  wr_en_o;
  logic [ADDR_WIDTH-1:0] wr_address_o;
  logic [DATA_WIDTH-1:0] wr_data_o;
  logic                  ext_wr_req_i;
  logic [ADDR_WIDTH-1:0] ext_wr_address_i;
  logic [DATA_WIDTH-1:0] ext_wr_data_i;
  logic                  ext_wr_ack_o;

  modport slave (
    input  start_i, rd_data_1_i, rd_data_2_i,
    input  ext_wr_req_i, ext_wr_address_i, ext_wr_data_i,
    output busy_o, done_o, rd_address_1_o, rd_address_2_o,
    output wr_en_o, wr_address_o, wr_data_o, ext_wr_ack_o
  );

  modport master (
    output start_i, rd_data_1_i, rd_data_2_i,
    output ext_wr_req_i, ext_wr_address_i, ext_wr_data_i,
    input  busy_o, done_o, rd_address_1_o, rd_address_2_o,
    input  wr_en_o, wr_address_o, wr_data_o, ext_wr_ack_o
  );
endinterface

// File: rtl/sand_update_scheduler.sv
// Falling-sand grid update scheduler: one bottom-up pass per start request, brush writes while idle.
// Define DIAGONAL_FALL_EN to let blocked grains slide to the lower-left or lower-right cell.
module sand_update_scheduler #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 8,
  parameter int GRID_WIDTH  = 16,
  parameter int GRID_HEIGHT = 16
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  sand_update_scheduler_if.slave  bus
);

  localparam int ROW_W = (GRID_HEIGHT > 1) ? $clog2(GRID_HEIGHT) : 1;
  localparam int COL_W = (GRID_WIDTH > 1) ? $clog2(GRID_WIDTH) : 1;
  localparam logic [ROW_W-1:0]      ROW_FIRST = ROW_W'(GRID_HEIGHT - 2);
  localparam logic [COL_W-1:0]      COL_LAST  = COL_W'(GRID_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] GW_A      = ADDR_WIDTH'(GRID_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] ONE_A     = ADDR_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ISSUE      = 3'd1,
    S_EVAL       = 3'd2,
    S_WR_DST     = 3'd3,
    S_WR_SRC     = 3'd4
`ifdef DIAGONAL_FALL_EN
    ,
    S_DIAG_ISSUE = 3'd5,
    S_DIAG_EVAL  = 3'd6
`endif
  } state_t;

  state_t                state_q, state_d;
  logic                  pending_q, pending_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic [COL_W-1:0]      col_q, col_d;
  logic [DATA_WIDTH-1:0] src_val_q, src_val_d;
  logic [ADDR_WIDTH-1:0] dst_addr_q, dst_addr_d;
  logic                  done_q, done_d;

  logic [ADDR_WIDTH-1:0] src_addr_s;
  logic [ADDR_WIDTH-1:0] below_addr_s;
  logic                  advance_s;
  logic                  go_s;
  logic                  src_full_s;
  logic                  below_empty_s;

  assign src_addr_s    = ADDR_WIDTH'(row_q) * GW_A + ADDR_WIDTH'(col_q);
  assign below_addr_s  = src_addr_s + GW_A;
  assign go_s          = (pending_q | bus.start_i) & ~bus.ext_wr_req_i;
  assign src_full_s    = (bus.rd_data_1_i != '0);
  assign below_empty_s = (bus.rd_data_2_i == '0);

  // State and scan-position registers.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      pending_q  <= 1'b0;
      row_q      <= '0;
      col_q      <= '0;
      src_val_q  <= '0;
      dst_addr_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      row_q      <= row_d;
      col_q      <= col_d;
      src_val_q  <= src_val_d;
      dst_addr_q <= dst_addr_d;
      done_q     <= done_d;
    end
  end

  // Next-state, scan stepping and end-of-pass detection.
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    row_d      = row_q;
    col_d      = col_q;
    src_val_d  = src_val_q;
    dst_addr_d = dst_addr_q;
    done_d     = 1'b0;
    advance_s  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (go_s) begin
          pending_d = 1'b0;
          state_d   = S_ISSUE;
          row_d     = ROW_FIRST;
          col_d     = '0;
        end else begin
          pending_d = pending_q | bus.start_i;
        end
      end
      S_ISSUE: begin
        state_d = S_EVAL;
      end
      S_EVAL: begin
        if (src_full_s && below_empty_s) begin
          src_val_d  = bus.rd_data_1_i;
          dst_addr_d = below_addr_s;
          state_d    = S_WR_DST;
`ifdef DIAGONAL_FALL_EN
        end else if (src_full_s) begin
          src_val_d = bus.rd_data_1_i;
          state_d   = S_DIAG_ISSUE;
`endif
        end else begin
          advance_s = 1'b1;
        end
      end
`ifdef DIAGONAL_FALL_EN
      S_DIAG_ISSUE: begin
        state_d = S_DIAG_EVAL;
      end
      S_DIAG_EVAL: begin
        // Left wins over right when both diagonals are free.
        if ((col_q != '0) && (bus.rd_data_1_i == '0)) begin
          dst_addr_d = below_addr_s - ONE_A;
          state_d    = S_WR_DST;
        end else if ((col_q != COL_LAST) && below_empty_s) begin
          dst_addr_d = below_addr_s + ONE_A;
          state_d    = S_WR_DST;
        end else begin
          advance_s = 1'b1;
        end
      end
`endif
      S_WR_DST: begin
        state_d = S_WR_SRC;
      end
      S_WR_SRC: begin
        advance_s = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (advance_s) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        if (row_q == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          row_d   = row_q - ROW_W'(1);
          state_d = S_ISSUE;
        end
      end else begin
        col_d   = col_q + COL_W'(1);
        state_d = S_ISSUE;
      end
    end else begin
      done_d = 1'b0;
    end
  end

  // Memory port and handshake decode from the current state.
  always_comb begin
    bus.rd_address_1_o = '0;
    bus.rd_address_2_o = '0;
    bus.wr_en_o        = 1'b0;
    bus.wr_address_o   = '0;
    bus.wr_data_o      = '0;
    bus.ext_wr_ack_o   = 1'b0;

    case (state_q)
      S_IDLE: begin
        // The brush is served combinationally so the ack lands in the request cycle.
        if (bus.ext_wr_req_i && !reset_i) begin
          bus.wr_en_o      = 1'b1;
          bus.wr_address_o = bus.ext_wr_address_i;
          bus.wr_data_o    = bus.ext_wr_data_i;
          bus.ext_wr_ack_o = 1'b1;
        end else begin
          bus.ext_wr_ack_o = 1'b0;
        end
      end
      S_ISSUE: begin
        bus.rd_address_1_o = src_addr_s;
        bus.rd_address_2_o = below_addr_s;
      end
`ifdef DIAGONAL_FALL_EN
      S_DIAG_ISSUE: begin
        bus.rd_address_1_o = (col_q != '0)       ? (below_addr_s - ONE_A) : below_addr_s;
        bus.rd_address_2_o = (col_q != COL_LAST) ? (below_addr_s + ONE_A) : below_addr_s;
      end
`endif
      S_WR_DST: begin
        bus.wr_en_o      = 1'b1;
        bus.wr_address_o = dst_addr_q;
        bus.wr_data_o    = src_val_q;
      end
      S_WR_SRC: begin
        bus.wr_en_o      = 1'b1;
        bus.wr_address_o = src_addr_s;
        bus.wr_data_o    = '0;
      end
      default: begin
        bus.wr_en_o = 1'b0;
      end
    endcase
  end

  assign bus.busy_o = (state_q != S_IDLE);
  assign bus.done_o = done_q;

endmodule

// File: tb/tb_sand_update_scheduler.sv
// Directed bench for sand_update_scheduler on a 4x4 grid with a registered-read memory model.
module tb_sand_update_scheduler;
  localparam int AW    = 8;
  localparam int DW    = 8;
  localparam int GW    = 4;
  localparam int GH    = 4;
  localparam int CELLS = GW * GH;

  logic clk = 1'b0;
  logic reset_i;
  always #5 clk = ~clk;

  sand_update_scheduler_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  sand_update_scheduler #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .GRID_WIDTH(GW), .GRID_HEIGHT(GH)
  ) dut (
    .clk_i  (clk),
    .reset_i(reset_i),
    .bus    (bus)
  );

  logic [DW-1:0] mem [0:CELLS-1];
  int wr_cnt   = 0;
  int done_cnt = 0;
  int oob_cnt  = 0;
  int errors   = 0;
  int checks   = 0;

  // Cell memory: synchronous write, one-cycle read latency, plus activity counters.
  always @(posedge clk) begin
    if (bus.wr_en_o) begin
      wr_cnt <= wr_cnt + 1;
      if (bus.wr_address_o < AW'(CELLS)) mem[bus.wr_address_o[3:0]] <= bus.wr_data_o;
      else oob_cnt <= oob_cnt + 1;
    end
    if (bus.busy_o && (bus.rd_address_1_o >= AW'(CELLS) || bus.rd_address_2_o >= AW'(CELLS)))
      oob_cnt <= oob_cnt + 1;
    if (bus.done_o) done_cnt <= done_cnt + 1;
    bus.rd_data_1_i <= mem[bus.rd_address_1_o[3:0]];
    bus.rd_data_2_i <= mem[bus.rd_address_2_o[3:0]];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic ext_write(input int a, input int d);
    @(negedge clk);
    bus.ext_wr_req_i     = 1'b1;
    bus.ext_wr_address_i = AW'(a);
    bus.ext_wr_data_i    = DW'(d);
    @(negedge clk);
    bus.ext_wr_req_i     = 1'b0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < CELLS; i++) ext_write(i, 0);
  endtask

  task automatic wait_done(output int busy_cycles, output bit got);
    busy_cycles = 0;
    got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      if (bus.done_o) got = 1'b1;
      else begin
        if (bus.busy_o) busy_cycles++;
        @(negedge clk);
      end
    end
  endtask

  task automatic run_pass(input string tag, input int exp_busy, input int exp_wr);
    int w0, d0, bc;
    bit got;
    w0 = wr_cnt;
    d0 = done_cnt;
    @(negedge clk);
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    wait_done(bc, got);
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    check({tag, "_busy_cycles"}, 32'(bc), 32'(exp_busy));
    @(negedge clk);
    check({tag, "_done_single"}, 32'(bus.done_o), 32'd0);
    check({tag, "_done_count"}, 32'(done_cnt - d0), 32'd1);
    check({tag, "_writes"}, 32'(wr_cnt - w0), 32'(exp_wr));
  endtask

  initial begin
    int  bc, d0;
    bit  got, seen;

    reset_i              = 1'b1;
    bus.start_i          = 1'b0;
    bus.ext_wr_req_i     = 1'b1;
    bus.ext_wr_address_i = AW'(5);
    bus.ext_wr_data_i    = DW'(8'hAA);
    #1;
    check("rst_busy",  32'(bus.busy_o),         32'd0);
    check("rst_done",  32'(bus.done_o),         32'd0);
    check("rst_wr_en", 32'(bus.wr_en_o),        32'd0);
    check("rst_ack",   32'(bus.ext_wr_ack_o),   32'd0);
    check("rst_waddr", 32'(bus.wr_address_o),   32'd0);
    check("rst_wdata", 32'(bus.wr_data_o),      32'd0);
    check("rst_raddr", 32'(bus.rd_address_1_o), 32'd0);
    repeat (2) @(negedge clk);
    bus.ext_wr_req_i = 1'b0;
    reset_i = 1'b0;
    clear_mem();

    // Empty grid: 12 source cells at 2 cycles each, nothing written.
    run_pass("empty", 24, 0);

    // Single grain drops one row per pass.
    ext_write(1, 1);
    run_pass("p1", 26, 2);
    check("p1_mem5", 32'(mem[5]), 32'd1);
    check("p1_mem1", 32'(mem[1]), 32'd0);
    run_pass("p2", 26, 2);
    run_pass("p3", 26, 2);
    check("p3_mem13", 32'(mem[13]), 32'd1);
    check("p3_mem9",  32'(mem[9]),  32'd0);

    // Two-high column resting on the floor.
    clear_mem();
    ext_write(9, 1);
    ext_write(13, 1);
`ifdef DIAGONAL_FALL_EN
    run_pass("stack", 28, 2);
    check("stack_mem12", 32'(mem[12]), 32'd1);
    check("stack_mem9",  32'(mem[9]),  32'd0);
    check("stack_mem13", 32'(mem[13]), 32'd1);
`else
    run_pass("stack", 24, 0);
    check("stack_mem9",  32'(mem[9]),  32'd1);
    check("stack_mem13", 32'(mem[13]), 32'd1);
`endif

    // Brush write and start in the same idle cycle: write first, then the pass.
    clear_mem();
    @(negedge clk);
    bus.ext_wr_req_i     = 1'b1;
    bus.ext_wr_address_i = AW'(3);
    bus.ext_wr_data_i    = DW'(1);
    bus.start_i          = 1'b1;
    #1;
    check("both_ack",   32'(bus.ext_wr_ack_o), 32'd1);
    check("both_wr_en", 32'(bus.wr_en_o),      32'd1);
    check("both_waddr", 32'(bus.wr_address_o), 32'd3);
    check("both_wdata", 32'(bus.wr_data_o),    32'd1);
    check("both_busy0", 32'(bus.busy_o),       32'd0);
    @(negedge clk);
    bus.ext_wr_req_i = 1'b0;
    bus.start_i      = 1'b0;
    #1;
    check("both_busy1", 32'(bus.busy_o), 32'd0);
    @(negedge clk);
    bus.ext_wr_req_i     = 1'b1;
    bus.ext_wr_address_i = AW'(15);
    bus.ext_wr_data_i    = DW'(0);
    #1;
    check("busy_started", 32'(bus.busy_o),       32'd1);
    check("busy_no_ack",  32'(bus.ext_wr_ack_o), 32'd0);
    check("busy_no_wr",   32'(bus.wr_en_o),      32'd0);
    bus.ext_wr_req_i = 1'b0;
    wait_done(bc, got);
    check("both_done_seen", 32'(got), 32'd1);
    check("both_busy_cycles", 32'(bc), 32'd26);
    @(negedge clk);
    check("both_mem7", 32'(mem[7]), 32'd1);
    check("both_mem3", 32'(mem[3]), 32'd0);

    // Reset while the destination write is on the bus.
    clear_mem();
    ext_write(9, 1);
    d0 = done_cnt;
    @(negedge clk);
    bus.start_i = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (bus.wr_en_o) seen = 1'b1;
      else @(negedge clk);
    end
    check("abort_wr_seen", 32'(seen), 32'd1);
    check("abort_dst",     32'(bus.wr_address_o), 32'd13);
    reset_i = 1'b1;
    #1;
    check("abort_wr_en", 32'(bus.wr_en_o), 32'd0);
    check("abort_busy",  32'(bus.busy_o),  32'd0);
    check("abort_done",  32'(bus.done_o),  32'd0);
    repeat (2) @(negedge clk);
    reset_i = 1'b0;
    repeat (5) @(negedge clk);
    check("abort_idle",    32'(bus.busy_o),        32'd0);
    check("abort_no_done", 32'(done_cnt - d0),     32'd0);
    check("abort_mem13",   32'(mem[13]),           32'd0);
    check("abort_mem9",    32'(mem[9]),            32'd1);

    run_pass("recover", 26, 2);
    check("recover_mem13", 32'(mem[13]), 32'd1);

    check("addr_range", 32'(oob_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sand_update_scheduler.md
SAND_UPDATE_SCHEDULER -- requirements
Module: sand_update_scheduler

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8: width of cell-memory address.
REQ-002 SHALL have parameter DATA_WIDTH, default 8: width of one cell; all-zeros means empty, any nonzero value means a falling grain.
REQ-003 SHALL have parameter GRID_WIDTH, default 16: cells per row.
REQ-004 SHALL have parameter GRID_HEIGHT, default 16: rows; cell address = row*GRID_WIDTH + col, row 0 at top.
REQ-005 SHALL have port clk_i, input, 1: single clock, all logic on rising edge.
REQ-006 SHALL have port reset_i, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port start_i, input, 1: one-cycle pulse requesting one full grid update pass.
REQ-008 SHALL have ports busy_o (output, 1) and done_o (output, 1): pass in progress; one-cycle pulse at pass end.
REQ-009 SHALL have ports rd_address_1_o and rd_address_2_o (output, ADDR_WIDTH), plus rd_data_1_i and rd_data_2_i (input, DATA_WIDTH): two read ports of the cell memory, data valid one cycle after address.
REQ-010 SHALL have ports wr_en_o (output, 1), wr_address_o (output, ADDR_WIDTH) and wr_data_o (output, DATA_WIDTH): single memory write port.
REQ-011 SHALL have ports ext_wr_req_i (input, 1), ext_wr_address_i (input, ADDR_WIDTH), ext_wr_data_i (input, DATA_WIDTH) and ext_wr_ack_o (output, 1): external (user-brush) write requester.

Function
REQ-012 SHALL implement states IDLE, ISSUE, EVAL, WR_DST, WR_SRC (plus DIAG_ISSUE, DIAG_EVAL per REQ-026).
REQ-013 In IDLE with ext_wr_req_i=1, SHALL drive wr_en_o=1 with the ext address and data, and assert ext_wr_ack_o, in the same cycle; only one ack per cycle.
REQ-014 In IDLE, SHALL latch start_i into a pending flag; when the pending flag is set and ext_wr_req_i=0, SHALL clear the flag, enter ISSUE and set busy_o=1 on the next cycle.
REQ-015 Outside IDLE, SHALL ignore start_i and hold ext_wr_ack_o=0; ext requests wait.
REQ-016 Scan order SHALL be row GRID_HEIGHT-2 down to 0, and col 0 up to GRID_WIDTH-1 within a row; the bottom row is never a source.
REQ-017 ISSUE SHALL drive rd_address_1_o = src (row,col) and rd_address_2_o = src+GRID_WIDTH, then go to EVAL.
REQ-018 EVAL SHALL go to WR_DST if rd_data_1_i != 0 and rd_data_2_i == 0; otherwise SHALL advance to the next cell (ISSUE) or finish.
REQ-019 WR_DST SHALL write the registered source value to the destination; WR_SRC SHALL write zero to the source, then advance.
REQ-020 Per-cell latency SHALL be 2 cycles without a move and 4 cycles with a vertical move.
REQ-021 After the last cell (row 0, col GRID_WIDTH-1), SHALL return to IDLE, deassert busy_o and pulse done_o for exactly one cycle.
REQ-022 wr_en_o SHALL be 0 in every state except WR_DST, WR_SRC and acked IDLE writes.
REQ-023 Row and column counters SHALL wrap only at the REQ-016 bounds; no address SHALL exceed GRID_WIDTH*GRID_HEIGHT-1.

Reset
REQ-024 On reset_i=1, SHALL immediately go to IDLE and clear the pending flag and counters; busy_o, done_o, wr_en_o and ext_wr_ack_o SHALL be 0, and all address and data outputs SHALL be 0.
REQ-025 Reset mid-pass SHALL abort with no further writes; memory is not restored, and a half-completed move (WR_DST done, WR_SRC not done) is permitted.

Configuration
REQ-026 Macro DIAGONAL_FALL_EN: when defined, EVAL with an occupied cell below SHALL go to DIAG_ISSUE, which reads below-left on port 1 and below-right on port 2. DIAG_EVAL SHALL move the grain to below-left if col>0 and that cell is empty, else to below-right if col<GRID_WIDTH-1 and that cell is empty, else advance; a diagonal move costs 6 cycles. When the macro is undefined, the DIAG states SHALL be absent and grains move only vertically.

Verification
REQ-027 Grid 4x4 all zero, single start_i pulse -> busy_o for 2*12=24 cycles, done_o one pulse, no writes.
REQ-028 Grain 0x01 at addr 1 -> after one pass, addr 5=0x01 and addr 1=0; after three passes, addr 13=0x01.
REQ-029 Column stack: addr 9 and 13 =0x01 (no DIAGONAL_FALL_EN) -> no writes, memory unchanged.
REQ-030 ext_wr_req_i and start_i asserted together in IDLE -> ext write acked first (addr 3 data 0x01), pass starts next cycle, and the grain falls to addr 7.
REQ-031 reset_i asserted during WR_DST -> wr_en_o=0 from that edge, IDLE, busy_o=0, no done_o pulse.
REQ-032 DIAGONAL_FALL_EN, grains at addr 9 and 13, addr 12 empty -> addr 9 moves to addr 12.
